result_streamer: RTL
====================

// Module: result_streamer
// PURPOSE
//  Drains the flattened 4x4 result matrix produced by the matrix-multiply FSM/MAC datapath.
//  On the completion edge of done_in, it snapshots C_in_flat into a local buffer.
//  It then streams the elements out one per transfer, row-major, over a valid/ready interface.
//  It is the consumer end of the C_out/done result interface; it lets a narrow downstream
//  (UART bridge, scoreboard, bus master) read results without 256-bit wiring.
// PARAMETERS
//  N       4   matrix dimension (N x N elements); N >= 2
//  DATA_W  16  width of one result element (matches MAC accumulator width)
//  IDX_W   $clog2(N)  derived local width of row/col indices (not overridable)
// PORTS
//  clk        in   1             system clock, all state on rising edge
//  reset      in   1             asynchronous, active-low reset (0 = reset)
//  done_in    in   1             completion flag from FSM; level or pulse, rising edge used
//  C_in_flat  in   N*N*DATA_W    result matrix; element (i,j) at [(i*N+j)*DATA_W +: DATA_W]
//  m_ready    in   1             downstream can accept current element
//  m_valid    out  1             m_data/m_row/m_col/m_last hold a valid element
//  m_data     out  DATA_W        element value
//  m_row      out  IDX_W         row index i of m_data
//  m_col      out  IDX_W         column index j of m_data
//  m_last     out  1             high with the final element (i=j=N-1)
//  busy       out  1             high from capture until the final transfer completes
//  overrun    out  1             sticky: a done edge arrived while busy and was dropped
// BEHAVIOUR
//  Reset (reset=0, async): all outputs 0, buffer 0, index counter 0, done_d 0, state IDLE.
//  done edge: done_rise = done_in & ~done_d; done_d <= done_in every cycle.
//   - Because done_d resets to 0, done_in high when reset releases counts as an edge.
//  State machine, two states:
//   IDLE:
//    - m_valid=0, busy=0.
//    - On done_rise: buffer <= C_in_flat, k <= 0, go STREAM.
//    - m_valid=1 and busy=1 the next cycle (capture latency 1 clk).
//   STREAM:
//    - m_valid=1. m_data=buffer[k*DATA_W +: DATA_W], m_row=k/N, m_col=k%N.
//    - m_last=(k==N*N-1).
//    - Transfer occurs when m_valid & m_ready in a cycle.
//    - Transfer with k<N*N-1: k <= k+1, so the next element is presented the following cycle.
//    - m_valid & ~m_ready: all m_* outputs must stay stable; k holds; there is no timeout.
//    - Transfer with k==N*N-1 and no done_rise: go IDLE; m_valid=0 and busy=0 the next cycle.
//    - Transfer with k==N*N-1 plus a simultaneous done_rise: the new matrix is accepted.
//      buffer <= C_in_flat, k <= 0, stay in STREAM (back-to-back streams, no bubble).
//    - done_rise in any other STREAM cycle: it is ignored, overrun <= 1, buffer is untouched.
//  overrun is cleared only by reset.
//  m_ready is ignored while m_valid=0.
//  C_in_flat is sampled only on the capture cycle; later changes do not affect the stream.
//  Throughput: 1 element/clk with m_ready tied high, so a full matrix takes N*N clks after capture.
//  Reset asserted mid-stream aborts the stream immediately; the partial matrix is not resumed.
//  Indices: k counter width $clog2(N*N); m_row/m_col are taken directly from k when N is a power of 2.
// TESTING
//  1. Hold reset=0, then release with done_in=0
//     -> all outputs 0; m_valid stays 0 for 10 clks.
//  2. Element (i,j) = 16'h0100*i + j; pulse done_in 1 clk; m_ready=1
//     -> m_valid rises 1 clk later; 16 consecutive transfers 0000,0001,...,0303.
//     -> row/col match; m_last only on 0303; busy then drops.
//  3. Same matrix; m_ready toggles 1,0,0,1 repeatedly
//     -> no element lost or duplicated; outputs stable while stalled; order unchanged.
//  4. done_in held high 40 clks after one stream
//     -> exactly one stream; overrun stays 0.
//     -> C_in_flat changed after capture does not alter streamed data.
//  5. New done edge at the 5th transfer
//     -> overrun=1, stream completes with the original data.
//     -> New done edge on the m_last transfer: second stream starts next clk, no idle cycle.
//  6. Assert reset during the 7th element stall
//     -> m_valid, busy and overrun go 0 immediately, without waiting for a clk edge.
//     -> After release plus a done pulse, the stream restarts at (0,0).

Source files
------------

// File: rtl/result_streamer.sv
// Captures the flattened N x N result matrix on a done_in rising edge and
// streams it out row-major, one element per valid/ready transfer.
module result_streamer #(
    parameter int N      = 4,
    parameter int DATA_W = 16,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    done_in,
    input  logic [N*N*DATA_W-1:0]   C_in_flat,
    input  logic                    m_ready,
    output logic                    m_valid,
    output logic [DATA_W-1:0]       m_data,
    output logic [IDX_W-1:0]        m_row,
    output logic [IDX_W-1:0]        m_col,
    output logic                    m_last,
    output logic                    busy,
    output logic                    overrun
);

    localparam int K_W    = $clog2(N * N);
    localparam int LAST_K = N * N - 1;

    typedef enum logic {
        IDLE,
        STREAM
    } state_e;

    state_e                  state_q, state_d;
    logic [K_W-1:0]          k_q, k_d;
    logic [N*N*DATA_W-1:0]   buf_q, buf_d;
    logic                    done_q;
    logic                    overrun_q, overrun_d;

    logic                    done_rise;
    logic                    last_k;
    logic                    xfer;
    logic                    streaming;

    assign streaming = (state_q == STREAM);
    assign done_rise = done_in & ~done_q;
    assign last_k    = (k_q == K_W'(LAST_K));
    assign xfer      = streaming & m_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            k_q       <= '0;
            buf_q     <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            buf_q     <= buf_d;
            done_q    <= done_in;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        buf_d     = buf_q;
        overrun_d = overrun_q;
        case (state_q)
            IDLE: begin
                if (done_rise) begin
                    buf_d   = C_in_flat;
                    k_d     = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (xfer && last_k) begin
                    // A new matrix arriving exactly on the final transfer chains with no bubble.
                    if (done_rise) begin
                        buf_d = C_in_flat;
                        k_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (xfer) begin
                        k_d = k_q + K_W'(1);
                    end
                    if (done_rise) begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Element outputs are forced to zero outside a stream so idle cycles show a clean bus.
    always_comb begin
        m_valid = streaming;
        busy    = streaming;
        overrun = overrun_q;
        m_data  = '0;
        m_row   = '0;
        m_col   = '0;
        m_last  = 1'b0;
        if (streaming) begin
            m_data = buf_q[int'(k_q) * DATA_W +: DATA_W];
            m_row  = IDX_W'(k_q / K_W'(N));
            m_col  = IDX_W'(k_q % K_W'(N));
            m_last = last_k;
        end
    end

endmodule
